// File: rtl/seq_checker.sv
// seq_checker: locks onto the 3-bit cyclic code stream 000->010->011->101->110->000,
// checks each sampled transition against the expected successor, and reports lock
// status, single-cycle error/wrap strobes and a saturating error count.
module seq_checker #(
    parameter int LOCK_COUNT = 3,
    parameter int LOSS_COUNT = 2,
    parameter int ERR_W      = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    input  logic [2:0]       in_code,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic             wrap_pulse,
    output logic [ERR_W-1:0] err_count
);

    localparam logic [1:0] HUNT   = 2'd0;
    localparam logic [1:0] ACQ    = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam int GW = (LOCK_COUNT > 1) ? $clog2(LOCK_COUNT + 1) : 1;
    localparam int BW = (LOSS_COUNT > 1) ? $clog2(LOSS_COUNT + 1) : 1;

    localparam logic [GW-1:0]    G_ONE  = GW'(1);
    localparam logic [GW-1:0]    G_LAST = GW'(LOCK_COUNT - 1);
    localparam logic [BW-1:0]    B_ONE  = BW'(1);
    localparam logic [BW-1:0]    B_LAST = BW'(LOSS_COUNT - 1);
    localparam logic [ERR_W-1:0] E_ONE  = ERR_W'(1);

    logic [1:0]       state, state_n;
    logic [2:0]       prev, prev_n;
    logic [GW-1:0]    good, good_n;
    logic [BW-1:0]    bad, bad_n;
    logic [ERR_W-1:0] errc_n;
    logic             err_n, wrap_n;
    logic [2:0]       expect_code;
    logic             match;

    function automatic logic [2:0] succ(input logic [2:0] c);
        logic [2:0] r;
        case (c)
            3'b000:  r = 3'b010;
            3'b010:  r = 3'b011;
            3'b011:  r = 3'b101;
            3'b101:  r = 3'b110;
            3'b110:  r = 3'b000;
            default: r = 3'b000;
        endcase
        return r;
    endfunction

    function automatic logic is_legal(input logic [2:0] c);
        return (c == 3'b000) || (c == 3'b010) || (c == 3'b011) ||
               (c == 3'b101) || (c == 3'b110);
    endfunction

    assign expect_code = succ(prev);
    assign match       = (in_code == expect_code);

    // Next-state, counter and strobe decisions for the current sample
    always_comb begin
        state_n = state;
        prev_n  = prev;
        good_n  = good;
        bad_n   = bad;
        err_n   = 1'b0;
        wrap_n  = 1'b0;
        if (in_valid) begin
            case (state)
                HUNT: begin
                    if (is_legal(in_code)) begin
                        prev_n  = in_code;
                        good_n  = '0;
                        state_n = ACQ;
                    end
                end
                ACQ: begin
                    if (match) begin
                        prev_n = in_code;
                        if (good == G_LAST) begin
                            state_n = LOCKED;
                            good_n  = '0;
                            bad_n   = '0;
                        end else begin
                            good_n = good + G_ONE;
                        end
                    end else if (is_legal(in_code)) begin
                        prev_n = in_code;
                        good_n = '0;
                    end else begin
                        state_n = HUNT;
                    end
                end
                LOCKED: begin
                    if (match) begin
                        prev_n = in_code;
                        bad_n  = '0;
                        wrap_n = (prev == 3'b110);
                    end else begin
                        // Flywheel: advance along the expected sequence so a single
                        // corrupt sample costs exactly one error.
                        err_n  = 1'b1;
                        prev_n = expect_code;
                        if (bad == B_LAST) begin
                            state_n = HUNT;
                            bad_n   = '0;
                        end else begin
                            bad_n = bad + B_ONE;
                        end
                    end
                end
                default: state_n = HUNT;
            endcase
        end
    end

    // Error counter: clear wins over accumulation but still counts a same-edge error
    always_comb begin
        errc_n = err_count;
        if (clr_err) begin
            errc_n = err_n ? E_ONE : '0;
        end else if (err_n && (err_count != '1)) begin
            errc_n = err_count + E_ONE;
        end
    end

    // State and registered outputs, asynchronously reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state      <= HUNT;
            prev       <= 3'b000;
            good       <= '0;
            bad        <= '0;
            locked     <= 1'b0;
            err_pulse  <= 1'b0;
            wrap_pulse <= 1'b0;
            err_count  <= '0;
        end else begin
            state      <= state_n;
            prev       <= prev_n;
            good       <= good_n;
            bad        <= bad_n;
            locked     <= (state_n == LOCKED);
            err_pulse  <= err_n;
            wrap_pulse <= wrap_n;
            err_count  <= errc_n;
        end
    end

endmodule

// File: tb/tb_seq_checker.sv
// tb_seq_checker: drives two seq_checker instances (default and ERR_W=2) with the
// same stimulus and compares them against a sequence-position reference model.
module tb_seq_checker;

    localparam int LOCK = 3;
    localparam int LOSS = 2;

    logic       clk = 1'b0;
    logic       rst;
    logic       in_valid;
    logic [2:0] in_code;
    logic       clr_err;

    logic       locked, err_pulse, wrap_pulse;
    logic [7:0] err_count;
    logic       locked2, err_pulse2, wrap_pulse2;
    logic [1:0] err_count2;

    seq_checker #(.LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS), .ERR_W(8)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code), .clr_err(clr_err),
        .locked(locked), .err_pulse(err_pulse), .wrap_pulse(wrap_pulse), .err_count(err_count)
    );

    seq_checker #(.LOCK_COUNT(LOCK), .LOSS_COUNT(LOSS), .ERR_W(2)) dut2 (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_code(in_code), .clr_err(clr_err),
        .locked(locked2), .err_pulse(err_pulse2), .wrap_pulse(wrap_pulse2), .err_count(err_count2)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Reference model: position of the previous code within the cycle
    int seq [5] = '{0, 2, 3, 5, 6};
    int m_mode;   // 0 hunting, 1 acquiring, 2 locked
    int m_pos;
    int m_good;
    int m_bad;
    int m_err8;
    int m_err2;
    bit m_errp;
    bit m_wrap;

    logic [15:0] obs;
    assign obs = {locked, err_pulse, wrap_pulse, err_count,
                  locked2, err_pulse2, wrap_pulse2, err_count2};

    function automatic int code_idx(input int c);
        for (int i = 0; i < 5; i++) if (seq[i] == c) return i;
        return -1;
    endfunction

    function automatic int next_code();
        return seq[(m_pos + 1) % 5];
    endfunction

    function automatic logic [15:0] model_vec();
        logic lk;
        lk = (m_mode == 2);
        return {lk, m_errp, m_wrap, 8'(m_err8), lk, m_errp, m_wrap, 2'(m_err2)};
    endfunction

    task automatic model_reset();
        m_mode = 0; m_pos = 0; m_good = 0; m_bad = 0;
        m_err8 = 0; m_err2 = 0; m_errp = 0; m_wrap = 0;
    endtask

    task automatic model_step(input bit v, input int c, input bit clr);
        int idx;
        m_errp = 0;
        m_wrap = 0;
        if (v) begin
            idx = code_idx(c);
            case (m_mode)
                0: if (idx >= 0) begin m_pos = idx; m_good = 0; m_mode = 1; end
                1: begin
                    if (c == next_code()) begin
                        m_pos = (m_pos + 1) % 5;
                        m_good++;
                        if (m_good == LOCK) begin m_mode = 2; m_bad = 0; end
                    end else if (idx >= 0) begin
                        m_pos = idx; m_good = 0;
                    end else begin
                        m_mode = 0;
                    end
                end
                default: begin
                    if (c == next_code()) begin
                        m_wrap = (m_pos == 4);
                        m_pos = (m_pos + 1) % 5;
                        m_bad = 0;
                    end else begin
                        m_errp = 1;
                        m_pos = (m_pos + 1) % 5;
                        m_bad++;
                        if (m_bad == LOSS) m_mode = 0;
                    end
                end
            endcase
        end
        if (clr) begin
            m_err8 = m_errp;
            m_err2 = m_errp;
        end else if (m_errp) begin
            m_err8 = (m_err8 < 255) ? m_err8 + 1 : 255;
            m_err2 = (m_err2 < 3) ? m_err2 + 1 : 3;
        end
    endtask

    // Apply one cycle of input, then sample 1 time unit after the edge
    task automatic drive(input bit v, input int c, input bit clr);
        in_valid = v;
        in_code  = 3'(c);
        clr_err  = clr;
        @(posedge clk);
        #1;
        model_step(v, c, clr);
    endtask

    task automatic test_reset();
        rst = 1'b1; in_valid = 1'b0; in_code = 3'b000; clr_err = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        total++;
        if (obs !== 16'h0) begin
            bad++; $display("FAIL reset_state got=%h exp=%h", obs, 16'h0);
        end
        rst = 1'b0;
        model_reset();
    endtask

    task automatic test_clean_stream();
        for (int i = 0; i < 12; i++) begin
            drive(1, seq[i % 5], 0);
            total++;
            if (obs !== model_vec()) begin
                bad++; $display("FAIL clean_model i=%0d got=%h exp=%h", i, obs, model_vec());
            end
            total++;
            if (locked !== (i >= 3)) begin
                bad++; $display("FAIL clean_locked i=%0d got=%b exp=%b", i, locked, (i >= 3));
            end
            total++;
            if (wrap_pulse !== (i == 5 || i == 10)) begin
                bad++; $display("FAIL clean_wrap i=%0d got=%b exp=%b", i, wrap_pulse, (i == 5 || i == 10));
            end
        end
        total++;
        if (err_count !== 8'd0) begin
            bad++; $display("FAIL clean_errcount got=%0d exp=0", err_count);
        end
    endtask

    task automatic test_single_corrupt();
        int  pulses = 0;
        bit  done = 0;
        int  c;
        for (int i = 0; i < 8; i++) begin
            c = next_code();
            if (c == 3 && !done) begin c = 7; done = 1; end
            drive(1, c, 0);
            if (err_pulse === 1'b1) pulses++;
            total++;
            if (obs !== model_vec()) begin
                bad++; $display("FAIL corrupt_model i=%0d got=%h exp=%h", i, obs, model_vec());
            end
        end
        total++;
        if (pulses != 1 || err_count !== 8'd1 || locked !== 1'b1) begin
            bad++; $display("FAIL corrupt_summary pulses=%0d cnt=%0d locked=%b exp 1/1/1", pulses, err_count, locked);
        end
    endtask

    task automatic test_loss_relock();
        int codes [7] = '{1, 1, 2, 3, 5, 6, 0};
        drive(1, next_code(), 1);
        total++;
        if (obs !== model_vec() || err_count !== 8'd0) begin
            bad++; $display("FAIL loss_clear got=%h exp=%h", obs, model_vec());
        end
        for (int i = 0; i < 7; i++) begin
            drive(1, codes[i], 0);
            total++;
            if (obs !== model_vec()) begin
                bad++; $display("FAIL loss_model i=%0d got=%h exp=%h", i, obs, model_vec());
            end
            total++;
            if (locked !== (i == 0 || i >= 5)) begin
                bad++; $display("FAIL loss_locked i=%0d got=%b exp=%b", i, locked, (i == 0 || i >= 5));
            end
            if (i == 1) begin
                total++;
                if (err_count !== 8'd2) begin
                    bad++; $display("FAIL loss_errcount got=%0d exp=2", err_count);
                end
            end
        end
    endtask

    task automatic test_valid_gaps();
        rst = 1'b1;
        #2;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 10; i++) begin
            drive(1, seq[i % 5], 0);
            total++;
            if (obs !== model_vec() || locked !== (i >= 3)) begin
                bad++; $display("FAIL gaps_valid i=%0d got=%h exp=%h", i, obs, model_vec());
            end
            drive(0, $urandom_range(0, 7), 0);
            total++;
            if (obs !== model_vec() || err_pulse !== 1'b0 || wrap_pulse !== 1'b0) begin
                bad++; $display("FAIL gaps_idle i=%0d got=%h exp=%h", i, obs, model_vec());
            end
        end
        total++;
        if (err_count !== 8'd0) begin
            bad++; $display("FAIL gaps_errcount got=%0d exp=0", err_count);
        end
    endtask

    task automatic test_clear_saturation();
        int pulses2 = 0;
        drive(1, 1, 1);
        total++;
        if (err_count !== 8'd1 || err_count2 !== 2'd1 || err_pulse !== 1'b1) begin
            bad++; $display("FAIL clr_same_edge got=%0d/%0d exp=1/1", err_count, err_count2);
        end
        drive(1, next_code(), 0);
        for (int k = 0; k < 5; k++) begin
            drive(1, 7, 0);
            if (err_pulse2 === 1'b1) pulses2++;
            total++;
            if (obs !== model_vec()) begin
                bad++; $display("FAIL sat_err k=%0d got=%h exp=%h", k, obs, model_vec());
            end
            drive(1, next_code(), 0);
            total++;
            if (obs !== model_vec()) begin
                bad++; $display("FAIL sat_match k=%0d got=%h exp=%h", k, obs, model_vec());
            end
        end
        total++;
        if (err_count2 !== 2'd3 || pulses2 != 5 || err_count !== 8'd6 || locked2 !== 1'b1) begin
            bad++; $display("FAIL saturation got cnt2=%0d pulses=%0d cnt=%0d exp 3/5/6", err_count2, pulses2, err_count);
        end
    endtask

    task automatic test_async_reset();
        #3;
        rst = 1'b1;
        #1;
        total++;
        if (obs !== 16'h0) begin
            bad++; $display("FAIL async_reset got=%h exp=%h", obs, 16'h0);
        end
        @(posedge clk);
        #1;
        rst = 1'b0;
        model_reset();
        for (int i = 0; i < 6; i++) begin
            drive(1, seq[i % 5], 0);
            total++;
            if (obs !== model_vec() || locked !== (i >= 3)) begin
                bad++; $display("FAIL reacquire i=%0d got=%h exp=%h", i, obs, model_vec());
            end
        end
    endtask

    task automatic test_random();
        bit v, clr;
        int c;
        for (int i = 0; i < 400; i++) begin
            v   = ($urandom % 5) != 0;
            c   = (($urandom % 8) == 0) ? int'($urandom % 8) : next_code();
            clr = ($urandom % 20) == 0;
            drive(v, c, clr);
            total++;
            if (obs !== model_vec()) begin
                bad++; $display("FAIL random i=%0d code=%0d got=%h exp=%h", i, c, obs, model_vec());
            end
        end
    endtask

    initial begin
        test_reset();
        test_clean_stream();
        test_single_corrupt();
        test_loss_relock();
        test_valid_gaps();
        test_clear_saturation();
        test_async_reset();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
